fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 16, width of fetch PC and memory address.
REQ-002 Parameter INSTR_W, default 16, instruction width; opcode = instr[INSTR_W-1:INSTR_W-4].
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 Parameter PC_STEP, default 2, fetch PC increment per instruction.
REQ-005 Parameter RESET_PC, default 0, fetch PC after reset.
REQ-006 clk  in  1  sole clock, all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 imem_req  out  1  fetch request to instruction memory.
REQ-009 imem_addr  out  ADDR_W  fetch address, valid while imem_req=1.
REQ-010 imem_ready  in  1  memory accepts the request this cycle.
REQ-011 imem_valid  in  1  response data present this cycle.
REQ-012 imem_data  in  INSTR_W  response instruction word.
REQ-013 redirect  in  1  branch/jump taken; flush and restart.
REQ-014 redirect_pc  in  ADDR_W  new fetch PC.
REQ-015 instr_valid  out  1  queue head valid.
REQ-016 instr  out  INSTR_W  queue head instruction.
REQ-017 instr_pc  out  ADDR_W  PC of queue head.
REQ-018 instr_ready  in  1  consumer takes head when instr_valid=1.
REQ-019 q_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-020 halted  out  1  fetch stopped after HLT (see Configuration).

Function
REQ-021 States: IDLE, WAIT, WAIT_DISCARD, HALTED; at most one memory request outstanding.
REQ-022 IDLE: imem_req=1 iff q_count<DEPTH; imem_addr=fetch_pc; req and addr held stable until imem_ready.
REQ-023 Accept (imem_req&imem_ready): fetch_pc += PC_STEP modulo 2^ADDR_W (0xFFFE+2 -> 0x0000); go WAIT; tag = old fetch_pc.
REQ-024 WAIT, imem_valid=1: push {imem_data, tag}; go IDLE; imem_valid ignored in IDLE and HALTED.
REQ-025 Response captured at edge N appears at head (if queue empty) with instr_valid=1 in cycle after N; no combinational bypass.
REQ-026 Pop when instr_valid&instr_ready; simultaneous push and pop leaves q_count unchanged; push never occurs when full (guaranteed by REQ-022).
REQ-027 instr_valid = (q_count!=0); instr/instr_pc undefined-but-stable when empty, held at last head value.
REQ-028 redirect has highest priority: queue cleared, fetch_pc <= redirect_pc, halted cleared; pop and push that cycle discarded.
REQ-029 redirect in WAIT, or in IDLE coincident with imem_ready accept -> WAIT_DISCARD; redirect in IDLE without accept or HALTED -> IDLE, imem_req deasserted that next cycle only if queue full.
REQ-030 WAIT_DISCARD: next imem_valid dropped (no push), then IDLE; further redirect updates fetch_pc, state unchanged; imem_req=0 throughout.
REQ-031 redirect coincident with imem_valid in WAIT: response dropped, go IDLE.
REQ-032 instr_valid=0 in cycle following any redirect.

Reset
REQ-033 rst asserted: state IDLE, fetch_pc=RESET_PC, q_count=0, instr_valid=0, halted=0, imem_req=0 while rst=1.
REQ-034 rst mid-transaction abandons outstanding request; response arriving after release with no request issued is ignored.
REQ-035 First cycle after rst release: imem_req=1, imem_addr=RESET_PC.

Configuration
REQ-036 Macro FETCH_HALT_DETECT_EN defined: response with opcode 4'hF is pushed, then state HALTED, halted=1, imem_req=0 until redirect or rst.
REQ-037 Macro undefined: opcode 4'hF treated as any instruction, HALTED unreachable, halted tied 0.

Verification
REQ-038 Reset release, 1-cycle memory, instr_ready=1, data 0x1234,0x2345 -> instr_pc 0x0000,0x0002, instr matches, one instr per 2 cycles.
REQ-039 instr_ready=0, DEPTH=4 -> q_count reaches 4, imem_req=0; one pop -> imem_req=1 next cycle, addr 0x0008.
REQ-040 Redirect to 0x0040 while WAIT on addr 0x0006 -> that response dropped, next imem_addr=0x0040, first instr_pc=0x0040.
REQ-041 redirect_pc=0xFFFE -> fetch addresses 0xFFFE then 0x0000.
REQ-042 With FETCH_HALT_DETECT_EN, data 0xF000 at 0x0004 -> pushed, halted=1, imem_req=0; redirect 0x0010 -> halted=0, imem_addr=0x0010.
REQ-043 rst asserted while WAIT, late imem_valid after release -> no push, q_count=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// fetch_queue: single-outstanding instruction fetcher feeding a DEPTH-entry in-order queue.
// Optional halt-on-opcode-4'hF stop when FETCH_HALT_DETECT_EN is defined.
module fetch_queue #(
  parameter int                 ADDR_W   = 16,
  parameter int                 INSTR_W  = 16,
  parameter int                 DEPTH    = 4,
  parameter int                 PC_STEP  = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic                      imem_ready,
  input  logic                      imem_valid,
  input  logic [INSTR_W-1:0]        imem_data,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      instr_valid,
  output logic [INSTR_W-1:0]        instr,
  output logic [ADDR_W-1:0]         instr_pc,
  input  logic                      instr_ready,
  output logic [$clog2(DEPTH):0]    q_count,
  output logic                      halted
);

  localparam int                PTR_W = $clog2(DEPTH);
  localparam int                CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT         = 2'd1,
    WAIT_DISCARD = 2'd2,
    HALTED       = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   tag;
  logic [INSTR_W-1:0]  data_mem [DEPTH];
  logic [ADDR_W-1:0]   pc_mem   [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic [INSTR_W-1:0]  last_instr;
  logic [ADDR_W-1:0]   last_pc;
  logic                accept;
  logic                push;
  logic                pop;
  logic                is_hlt;

`ifdef FETCH_HALT_DETECT_EN
  assign is_hlt = (imem_data[INSTR_W-1:INSTR_W-4] == 4'hF);
  assign halted = (state == HALTED);
`else
  assign is_hlt = 1'b0;
  assign halted = 1'b0;
`endif

  // Request is masked during reset so nothing is issued while rst is high.
  assign imem_req    = !rst && (state == IDLE) && (count != FULL);
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req && imem_ready;
  assign push        = (state == WAIT) && imem_valid && !redirect;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign q_count     = count;
  assign instr       = instr_valid ? data_mem[rd_ptr] : last_instr;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : last_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      tag      <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      case (state)
        IDLE:         state <= accept ? WAIT_DISCARD : IDLE;
        // A response landing with the redirect is the one we were waiting for.
        WAIT,
        WAIT_DISCARD: state <= imem_valid ? IDLE : WAIT_DISCARD;
        default:      state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tag      <= fetch_pc;
            fetch_pc <= fetch_pc + STEP;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_valid) state <= is_hlt ? HALTED : IDLE;
        end
        WAIT_DISCARD: begin
          if (imem_valid) state <= IDLE;
        end
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Head is shadowed every valid cycle so outputs hold the last head once empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]   <= tag;
    end
    if (instr_valid) begin
      last_instr <= data_mem[rd_ptr];
      last_pc    <= pc_mem[rd_ptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// tb_fetch_queue: table vectors, directed corner sequences and randomized traffic
// checked against a transaction-level queue model.
module tb_fetch_queue;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [2:0]  q_count;
  logic        halted;

  fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .q_count(q_count), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  bit          mem_busy = 0;
  logic [15:0] mem_a = '0;
  int          mem_wait = 0;
  int          mem_lat = 1;
  bit          mem_lat_rand = 0;
  bit          halt_on = 0;
  logic [15:0] halt_addr = '0;

  function automatic logic [15:0] data_of(input logic [15:0] a);
    logic [15:0] d;
    if (halt_on && a == halt_addr) return 16'hF000;
    d = 16'h1234 + (a >> 1) * 16'h1111;
    if (d[15:12] == 4'hF) d[15:12] = 4'hE;
    return d;
  endfunction

  // mode 0: always ready, 1: random ready, 2: never ready
  task automatic mem_drive(input int mode);
    imem_valid = 1'b0;
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem_valid = 1'b1;
        imem_data  = data_of(mem_a);
        mem_busy   = 0;
      end else mem_wait--;
    end
    imem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : 1'b0;
  endtask

  task automatic mem_commit();
    if (imem_req && imem_ready) begin
      mem_busy = 1;
      mem_a    = imem_addr;
      mem_wait = (mem_lat_rand ? int'($urandom_range(1, 3)) : mem_lat) - 1;
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [15:0] d; logic [15:0] pc; } ent_t;
  ent_t        m_q[$];
  logic [15:0] m_pc = '0;
  logic [15:0] m_tag = '0;
  bit          m_busy = 0;   // a request was accepted and its response is still due
  bit          m_drop = 0;   // that response must be thrown away
  bit          m_halt = 0;

  function automatic bit model_req();
    return !m_busy && !m_halt && (m_q.size() < 4);
  endfunction

  task automatic model_step(input bit ereq);
    bit   acc;
    ent_t e;
    acc = ereq && imem_ready;
    if (redirect) begin
      m_q.delete();
      m_pc   = redirect_pc;
      m_halt = 0;
      if (m_busy) begin
        if (imem_valid) begin m_busy = 0; m_drop = 0; end
        else m_drop = 1;
      end else if (acc) begin
        m_busy = 1; m_drop = 1;
      end
    end else begin
      if (instr_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (m_busy && imem_valid) begin
        m_busy = 0;
        if (!m_drop) begin
          e.d = imem_data; e.pc = m_tag;
          m_q.push_back(e);
          if (HALT_EN && imem_data[15:12] == 4'hF) m_halt = 1;
        end
        m_drop = 0;
      end
      if (acc) begin
        m_busy = 1; m_tag = m_pc; m_pc = m_pc + 16'd2;
      end
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic tick(input bit rd, input bit rdr, input logic [15:0] rpc, input int mode);
    bit ereq;
    mem_drive(mode);
    instr_ready = rd; redirect = rdr; redirect_pc = rpc;
    ereq = model_req();
    chk("imem_req", imem_req, ereq);
    if (ereq) chk("imem_addr", imem_addr, m_pc);
    chk("q_count", q_count, m_q.size());
    chk("instr_valid", instr_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("instr", instr, m_q[0].d);
      chk("instr_pc", instr_pc, m_q[0].pc);
    end
    chk("halted", halted, m_halt);
    model_step(ereq);
    mem_commit();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; redirect = 1'b0; instr_ready = 1'b0;
    #1;
    for (int i = 0; i < cycles; i++) begin
      mem_drive(2);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_q_count", q_count, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_halted", halted, 0);
      @(negedge clk);
    end
    rst = 1'b0;
    m_q.delete(); m_pc = 16'h0000; m_busy = 0; m_drop = 0; m_halt = 0;
    #1;
  endtask

  typedef struct {
    bit rd; bit req; logic [15:0] addr; bit val; logic [15:0] pc; logic [15:0] ins; int cnt;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0};
    tbl[1] = '{1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0};
    tbl[2] = '{1, 1, 16'h0002, 1, 16'h0000, 16'h1234, 1};
    tbl[3] = '{1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0};
    tbl[4] = '{1, 1, 16'h0004, 1, 16'h0002, 16'h2345, 1};
    tbl[5] = '{1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0};
    tbl[6] = '{1, 1, 16'h0006, 1, 16'h0004, 16'h3456, 1};

    @(negedge clk);

    // Streaming with a 1-cycle memory: one instruction every two cycles.
    do_reset(2);
    mem_lat = 1;
    for (int i = 0; i < 7; i++) begin
      chk("tbl_req", imem_req, tbl[i].req);
      if (tbl[i].req) chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_valid", instr_valid, tbl[i].val);
      chk("tbl_count", q_count, tbl[i].cnt);
      if (tbl[i].val) begin
        chk("tbl_pc", instr_pc, tbl[i].pc);
        chk("tbl_instr", instr, tbl[i].ins);
      end
      tick(tbl[i].rd, 0, 16'h0, 0);
    end

    // Back-pressure fills the queue; a single pop re-opens fetch at 0x0008.
    do_reset(1);
    for (int i = 0; i < 12; i++) tick(0, 0, 16'h0, 0);
    chk("full_count", q_count, 4);
    chk("full_req", imem_req, 0);
    tick(1, 0, 16'h0, 0);
    chk("refill_req", imem_req, 1);
    chk("refill_addr", imem_addr, 16'h0008);

    // Redirect while waiting on 0x0006 drops that response.
    do_reset(1);
    mem_lat = 3;
    n = 0;
    while (!(imem_req && imem_addr == 16'h0006) && n < 50) begin tick(1, 0, 16'h0, 0); n++; end
    chk("reach_addr6", imem_addr, 16'h0006);
    tick(1, 0, 16'h0, 0);
    tick(1, 1, 16'h0040, 0);
    chk("post_redirect_valid", instr_valid, 0);
    n = 0;
    while (!imem_req && n < 50) begin tick(1, 0, 16'h0, 0); n++; end
    chk("redirect_addr", imem_addr, 16'h0040);
    n = 0;
    while (!instr_valid && n < 50) begin tick(1, 0, 16'h0, 0); n++; end
    chk("redirect_first_pc", instr_pc, 16'h0040);

    // Fetch address wraps from 0xFFFE to 0x0000.
    mem_lat = 1;
    tick(1, 1, 16'hFFFE, 0);
    n = 0;
    while (!imem_req && n < 50) begin tick(1, 0, 16'h0, 0); n++; end
    chk("wrap_addr0", imem_addr, 16'hFFFE);
    tick(1, 0, 16'h0, 0);
    n = 0;
    while (!imem_req && n < 50) begin tick(1, 0, 16'h0, 0); n++; end
    chk("wrap_addr1", imem_addr, 16'h0000);

    // Reset during an outstanding request; the late response must be ignored.
    do_reset(1);
    mem_lat = 4;
    tick(0, 0, 16'h0, 0);
    tick(0, 0, 16'h0, 2);
    do_reset(1);
    for (int i = 0; i < 4; i++) tick(0, 0, 16'h0, 2);
    chk("late_count", q_count, 0);
    chk("late_req", imem_req, 1);
    chk("late_addr", imem_addr, 16'h0000);

    // Opcode 4'hF at 0x0004, then redirect to 0x0010.
    do_reset(1);
    mem_lat = 1; halt_on = 1; halt_addr = 16'h0004;
    for (int i = 0; i < 8; i++) tick(0, 0, 16'h0, 0);
`ifdef FETCH_HALT_DETECT_EN
    chk("hlt_halted", halted, 1);
    chk("hlt_req", imem_req, 0);
    chk("hlt_count", q_count, 3);
`else
    chk("hlt_halted", halted, 0);
    chk("hlt_count", q_count, 4);
`endif
    tick(0, 1, 16'h0010, 0);
    chk("hlt_clear", halted, 0);
    chk("hlt_redirect_req", imem_req, 1);
    chk("hlt_redirect_addr", imem_addr, 16'h0010);
    halt_on = 0;

    // Randomized traffic against the model.
    do_reset(1);
    mem_lat_rand = 1;
    for (int i = 0; i < 3000; i++)
      tick(($urandom % 4) != 0, ($urandom % 32) == 0, 16'($urandom) & 16'hFFFE, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
